// File: rtl/tt_um_ble_rx.sv
// BLE 1M GFSK receiver: FM discriminator, access-address correlator, slicer and dewhitener.
// Bytes appear one cycle after the edge that samples their last bit; no backpressure, ena=0 freezes everything.
module tt_um_ble_rx #(
  parameter int unsigned SPS        = 4,
  parameter logic [31:0] AA         = 32'h8E89BED6,
  parameter int unsigned AA_MAX_ERR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int unsigned HL = 31 * SPS + 1;
  localparam int unsigned PW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [5:0] MAX_ERR = 6'(AA_MAX_ERR);

  typedef enum logic {SEARCH, RECV} state_t;

  state_t            state_q;
  logic signed [3:0] ip_q, qp_q;
  logic [HL-2:0]     hist_q;
  logic [PW-1:0]     phase_q;
  logic [2:0]        bitcnt_q;
  logic [8:0]        bytecnt_q;
  logic [7:0]        len_q;
  logic [6:0]        lfsr_q;
  logic [6:0]        sh_q;
  logic [7:0]        uo_q;
  logic              vld_q;
  logic              sync_q;

  logic signed [8:0] i_x, q_x, ip_x, qp_x, disc;
  logic              raw;
  logic [HL-1:0]     hist_d;
  logic [5:0]        errs;
  logic              match;
  logic              dbit;
  logic              last_byte;
  logic              unused_ok;

  assign i_x  = {{5{ui_in[3]}}, ui_in[3:0]};
  assign q_x  = {{5{ui_in[7]}}, ui_in[7:4]};
  assign ip_x = {{5{ip_q[3]}}, ip_q};
  assign qp_x = {{5{qp_q[3]}}, qp_q};
  // Cross product of previous and current sample: positive means CCW rotation.
  assign disc = ip_x * q_x - qp_x * i_x;
  assign raw  = (disc > 9'sd0);

  assign hist_d = {hist_q, raw};

  always_comb begin
    errs = '0;
    for (int i = 0; i < 32; i++)
      errs = errs + {5'd0, AA[i] ^ hist_d[(31 - i) * SPS]};
  end

  assign match     = (errs <= MAX_ERR);
  assign dbit      = raw ^ lfsr_q[6];
  assign last_byte = (bytecnt_q >= 9'd2) && (bytecnt_q == ({1'b0, len_q} + 9'd4));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= SEARCH;
      ip_q      <= '0;
      qp_q      <= '0;
      hist_q    <= '0;
      phase_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      len_q     <= '0;
      lfsr_q    <= '0;
      sh_q      <= '0;
      uo_q      <= '0;
      vld_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else if (ena) begin
      ip_q   <= ui_in[3:0];
      qp_q   <= ui_in[7:4];
      hist_q <= hist_d[HL-2:0];
      vld_q  <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (match) begin
            state_q   <= RECV;
            sync_q    <= 1'b1;
            phase_q   <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            lfsr_q    <= {uio_in[0], uio_in[1], uio_in[2], uio_in[3], uio_in[4], uio_in[5], 1'b1};
          end
        end
        RECV: begin
          if (phase_q == PW'(SPS - 1)) begin
            phase_q <= '0;
            lfsr_q  <= {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2:0], lfsr_q[6]};
            sh_q    <= {dbit, sh_q[6:1]};
            if (bitcnt_q == 3'd7) begin
              bitcnt_q  <= '0;
              uo_q      <= {dbit, sh_q};
              vld_q     <= 1'b1;
              bytecnt_q <= bytecnt_q + 9'd1;
              if (bytecnt_q == 9'd1)
                len_q <= {dbit, sh_q};
              if (last_byte) begin
                sync_q  <= 1'b0;
                state_q <= SEARCH;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign uo_out    = uo_q;
  assign uio_out   = {vld_q, sync_q, 6'b0};
  assign uio_oe    = 8'hC0;
  assign unused_ok = &{1'b0, uio_in[7:6]};
endmodule

// File: tb/tb_tt_um_ble_rx.sv
// Bench for tt_um_ble_rx: directed GFSK packets, scoreboard queue of expected bytes, negedge monitor.
module tb_tt_um_ble_rx;
  localparam int SPS = 4;
  localparam logic [31:0] AA = 32'h8E89BED6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_ble_rx #(.SPS(SPS), .AA(AA), .AA_MAX_ERR(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] dat; logic last; } exp_t;
  exp_t       exp_q[$];
  exp_t       e_cur;
  int         tests = 0, fails = 0;
  int         pulses = 0, sync_rises = 0;
  logic       prev_vld = 1'b0, prev_sync = 1'b0;
  logic [1:0] ph = 2'd0;
  logic [6:0] wm;
  logic [7:0] pkt [32];
  int         pkt_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per byte_valid pulse.
  always @(negedge clk) begin
    if (uio_out[6] && !prev_sync) sync_rises++;
    if (uio_out[7]) begin
      pulses++;
      check("vld_one_cycle", {31'd0, prev_vld}, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", uo_out);
      end else begin
        e_cur = exp_q.pop_front();
        check("byte", {24'd0, uo_out}, {24'd0, e_cur.dat});
        check("sync_at_byte", {31'd0, uio_out[6]}, {31'd0, !e_cur.last});
      end
    end
    prev_vld  = uio_out[7];
    prev_sync = uio_out[6];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] iq(input logic [1:0] p);
    case (p)
      2'd0:    iq = {4'h0, 4'h7};
      2'd1:    iq = {4'h7, 4'h0};
      2'd2:    iq = {4'h0, 4'h9};
      default: iq = {4'h9, 4'h0};
    endcase
  endfunction

  task automatic sample(input logic b);
    ph    = b ? ph + 2'd1 : ph - 2'd1;
    ui_in = iq(ph);
    ena   = 1'b1;
    @(negedge clk);
  endtask

  task automatic sym(input logic b);
    repeat (SPS) sample(b);
  endtask

  task automatic idle(input int n);
    ena = 1'b0;
    repeat (n) begin
      ui_in = 8'($urandom);
      @(negedge clk);
    end
    ena = 1'b1;
  endtask

  task automatic noise(input int n);
    for (int k = 0; k < n; k++) sym(k % 3 == 0);
  endtask

  task automatic preamble_aa(input logic [31:0] a, input logic chk);
    logic [7:0] pre;
    pre = 8'h55;
    for (int i = 0; i < 8; i++) sym(pre[i]);
    for (int i = 0; i < 31; i++) sym(a[i]);
    if (chk) check("sync_before_aa31", {31'd0, uio_out[6]}, 0);
    sample(a[31]);
    if (chk) check("sync_at_aa31", {31'd0, uio_out[6]}, 1);
    repeat (SPS - 1) sample(a[31]);
  endtask

  task automatic whiten(input logic [7:0] b, output logic [7:0] o);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      o[i]  = b[i] ^ wm[6];
      fb    = wm[6];
      wm    = {wm[5:0], fb};
      wm[4] = wm[4] ^ fb;
    end
  endtask

  task automatic send_byte(input logic [7:0] air, input int gate_bit);
    for (int i = 0; i < 8; i++) begin
      if (i == gate_bit) idle(10);
      sym(air[i]);
    end
  endtask

  task automatic send_packet(input logic [5:0] ch, input int gate_byte, input int gate_bit);
    logic [7:0] air;
    exp_t       e;
    uio_in = {2'b00, ch};
    preamble_aa(AA, 1'b1);
    wm = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    for (int k = 0; k < pkt_n; k++) begin
      whiten(pkt[k], air);
      e.dat  = pkt[k];
      e.last = (k == pkt_n - 1);
      exp_q.push_back(e);
      send_byte(air, (k == gate_byte) ? gate_bit : 8);
      if (k == 2) uio_in = {2'b00, ~ch};
    end
  endtask

  int p0, r0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo_out", {24'd0, uo_out}, 0);
    check("rst_uio_out", {24'd0, uio_out}, 0);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'hC0);
    rst_n = 1'b0;
    @(negedge clk);
    check("uio_oe_run", {24'd0, uio_oe}, 32'hC0);
    noise(4);

    // Channel 0: hand-whitened 0x40, 0xB2 decode to 0x00, 0x00; then reset mid-byte
    p0 = pulses;
    uio_in = 8'd0;
    preamble_aa(AA, 1'b1);
    exp_q.push_back('{dat: 8'h00, last: 1'b0});
    send_byte(8'h40, 8);
    exp_q.push_back('{dat: 8'h00, last: 1'b0});
    send_byte(8'hB2, 8);
    sym(1'b1); sym(1'b0); sym(1'b1);
    #2 rst_n = 1'b1;
    #1;
    check("midrst_uio_out", {24'd0, uio_out}, 0);
    check("midrst_uio_oe", {24'd0, uio_oe}, 32'hC0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("ch0_pulses", pulses - p0, 2);
    check("ch0_queue_empty", exp_q.size(), 0);
    r0 = sync_rises;
    noise(10);
    check("no_sync_after_rst", sync_rises - r0, 0);

    // Single-bit AA error must not sync
    r0 = sync_rises;
    preamble_aa(AA ^ 32'h0000_2000, 1'b0);
    noise(16);
    check("flipped_aa_nosync", sync_rises - r0, 0);

    // Channel 37, L=6: 11 bytes
    pkt = '{default: 8'h00};
    pkt[0] = 8'h02; pkt[1] = 8'h06; pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33;
    pkt[5] = 8'h44; pkt[6] = 8'h55; pkt[7] = 8'h66; pkt[8] = 8'hA1; pkt[9] = 8'hB2;
    pkt[10] = 8'hC3;
    pkt_n = 11;
    p0 = pulses; r0 = sync_rises;
    noise(3);
    send_packet(6'd37, -1, 8);
    check("ch37_pulses", pulses - p0, 11);
    check("ch37_sync_rises", sync_rises - r0, 1);
    check("ch37_sync_low", {31'd0, uio_out[6]}, 0);

    // ena gating mid-byte
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'hDE; pkt[3] = 8'hAD;
    pkt[4] = 8'h5A; pkt[5] = 8'h3C; pkt[6] = 8'h0F;
    pkt_n = 7;
    p0 = pulses;
    noise(3);
    send_packet(6'd5, 2, 3);
    check("gated_pulses", pulses - p0, 7);

    // Back-to-back packets with 8 noise symbols between
    p0 = pulses; r0 = sync_rises;
    pkt[0] = 8'h03; pkt[1] = 8'h01; pkt[2] = 8'h77; pkt[3] = 8'h12; pkt[4] = 8'h34; pkt[5] = 8'h56;
    pkt_n = 6;
    send_packet(6'd12, -1, 8);
    noise(8);
    pkt[0] = 8'h0E; pkt[1] = 8'h00; pkt[2] = 8'h9A; pkt[3] = 8'hBC; pkt[4] = 8'hDE;
    pkt_n = 5;
    send_packet(6'd20, -1, 8);
    check("b2b_sync_rises", sync_rises - r0, 2);
    check("b2b_pulses", pulses - p0, 11);
    check("b2b_last_byte_held", {24'd0, uo_out}, 32'hDE);

    // Reset while holding a nonzero byte
    #2 rst_n = 1'b1;
    #1;
    check("rst2_uo_out", {24'd0, uo_out}, 0);
    check("rst2_uio_out", {24'd0, uio_out}, 0);
    check("rst2_uio_oe", {24'd0, uio_oe}, 32'hC0);
    @(negedge clk);
    rst_n = 1'b0;
    p0 = pulses; r0 = sync_rises;
    noise(12);
    check("rst2_no_sync", sync_rises - r0, 0);
    check("rst2_no_bytes", pulses - p0, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
